// File: rtl/ddr2_local_master_pkg.sv
// Shared types and default sizing for the DDR2 local-interface master.
package ddr2_local_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    localparam int DEF_ADDR_W    = 25;
    localparam int DEF_DATA_W    = 64;
    localparam int DEF_BE_W      = 8;
    localparam int DEF_SIZE_W    = 3;
    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_RD_DEPTH  = 16;

    // Wide enough to hold RD_DEPTH and compare against any cmd_len without wrap.
    function automatic int credit_w(input int size_w, input int depth);
        return size_w + $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ddr2_local_master_if.sv
// User command/data channels and controller local bus, grouped for the master.
interface ddr2_local_master_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 64,
    parameter int BE_W   = 8,
    parameter int SIZE_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [SIZE_W-1:0] cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              cmd_err;
    logic [ADDR_W-1:0] local_address;
    logic [SIZE_W-1:0] local_size;
    logic              local_burstbegin;
    logic              local_read_req;
    logic              local_write_req;
    logic [DATA_W-1:0] local_wdata;
    logic [BE_W-1:0]   local_be;
    logic              local_ready;
    logic [DATA_W-1:0] local_rdata;
    logic              local_rdata_valid;
    logic              local_init_done;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data, wr_be, rd_ready,
        input  local_ready, local_rdata, local_rdata_valid, local_init_done,
        output cmd_ready, wr_ready, rd_valid, rd_data, cmd_err,
        output local_address, local_size, local_burstbegin,
        output local_read_req, local_write_req, local_wdata, local_be
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data, wr_be, rd_ready,
        output local_ready, local_rdata, local_rdata_valid, local_init_done,
        input  cmd_ready, wr_ready, rd_valid, rd_data, cmd_err,
        input  local_address, local_size, local_burstbegin,
        input  local_read_req, local_write_req, local_wdata, local_be
    );

endinterface

// File: rtl/ddr2_local_master_rdfifo.sv
// First-word-fall-through read-return FIFO; head word is visible combinationally.
module ddr2_local_master_rdfifo #(
    parameter int DATA_W   = 64,
    parameter int RD_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_push,
    input  logic [DATA_W-1:0]           i_data,
    input  logic                        i_pop,
    output logic [DATA_W-1:0]           o_data,
    output logic [$clog2(RD_DEPTH):0]   o_count
);
    localparam int AW = $clog2(RD_DEPTH);

    logic [DATA_W-1:0] r_mem [RD_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/ddr2_local_master.sv
// DDR2 local-interface burst master with credit-guarded read FIFO.
// Optional counters enabled by defining DDR2_LOCAL_MASTER_STATS_EN.
module ddr2_local_master
    import ddr2_local_master_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BE_W      = DEF_BE_W,
    parameter int SIZE_W    = DEF_SIZE_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int RD_DEPTH  = DEF_RD_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    ddr2_local_master_if.master bus,
    output logic [31:0]         stat_wr_beats,
    output logic [31:0]         stat_rd_beats,
    output logic [31:0]         stat_stall
);
    localparam int CW    = credit_w(SIZE_W, RD_DEPTH);
    localparam int CNT_W = $clog2(RD_DEPTH) + 1;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [SIZE_W-1:0]  r_size;
    logic [SIZE_W-1:0]  r_beats;
    logic               r_first;
    logic               r_cmd_err;
    logic [CW-1:0]      r_credits;
    logic [CNT_W-1:0]   w_fifo_count;
    logic [DATA_W-1:0]  w_fifo_data;
    logic               w_len_ok;
    logic               w_cmd_ready;
    logic               w_cmd_fire;
    logic               w_accept;
    logic               w_rd_accept;
    logic               w_wr_beat;
    logic               w_rd_valid;
    logic               w_pop;

    assign w_len_ok    = (bus.cmd_len != '0) && (CW'(bus.cmd_len) <= CW'(MAX_BURST));
    assign w_cmd_ready = (r_state == IDLE) && bus.local_init_done &&
                         (bus.cmd_write || (r_credits >= CW'(bus.cmd_len)));
    assign w_cmd_fire  = bus.cmd_valid && w_cmd_ready;
    assign w_accept    = w_cmd_fire && w_len_ok;
    assign w_rd_accept = w_accept && !bus.cmd_write;
    assign w_wr_beat   = (r_state == WR) && bus.wr_valid && bus.local_ready;
    assign w_rd_valid  = (w_fifo_count != '0);
    assign w_pop       = w_rd_valid && bus.rd_ready;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next               = r_state;
        bus.local_write_req  = 1'b0;
        bus.local_read_req   = 1'b0;
        bus.local_burstbegin = 1'b0;
        bus.local_wdata      = '0;
        bus.local_be         = '0;
        bus.wr_ready         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = bus.cmd_write ? WR : RD;
            end
            WR: begin
                bus.local_write_req  = bus.wr_valid;
                bus.local_wdata      = bus.wr_data;
                bus.local_be         = bus.wr_be;
                bus.wr_ready         = bus.local_ready;
                bus.local_burstbegin = r_first && bus.wr_valid;
                if (w_wr_beat && (r_beats == SIZE_W'(1))) w_next = IDLE;
            end
            RD: begin
                bus.local_read_req   = 1'b1;
                bus.local_burstbegin = 1'b1;
                if (bus.local_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Credits are reserved at read acceptance and returned one per popped beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_size    <= '0;
            r_beats   <= '0;
            r_first   <= 1'b0;
            r_cmd_err <= 1'b0;
            r_credits <= CW'(RD_DEPTH);
        end else begin
            r_cmd_err <= w_cmd_fire && !w_len_ok;
            if (w_accept) begin
                r_addr  <= bus.cmd_addr;
                r_size  <= bus.cmd_len;
                r_beats <= bus.cmd_len;
                r_first <= 1'b1;
            end else if (w_wr_beat) begin
                r_beats <= r_beats - 1'b1;
                r_first <= 1'b0;
            end
            r_credits <= r_credits
                       - (w_rd_accept ? CW'(bus.cmd_len) : {CW{1'b0}})
                       + (w_pop ? CW'(1) : {CW{1'b0}});
        end
    end

    ddr2_local_master_rdfifo #(
        .DATA_W   (DATA_W),
        .RD_DEPTH (RD_DEPTH)
    ) u_rdfifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (bus.local_rdata_valid),
        .i_data  (bus.local_rdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count)
    );

    assign bus.cmd_ready     = w_cmd_ready;
    assign bus.cmd_err       = r_cmd_err;
    assign bus.local_address = r_addr;
    assign bus.local_size    = r_size;
    assign bus.rd_valid      = w_rd_valid;
    assign bus.rd_data       = w_rd_valid ? w_fifo_data : '0;

`ifdef DDR2_LOCAL_MASTER_STATS_EN
    logic [31:0] r_stat_wr;
    logic [31:0] r_stat_rd;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_wr    <= '0;
            r_stat_rd    <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_wr_beat)              r_stat_wr <= r_stat_wr + 1'b1;
            if (bus.local_rdata_valid)  r_stat_rd <= r_stat_rd + 1'b1;
            if ((bus.local_read_req || bus.local_write_req) && !bus.local_ready)
                r_stat_stall <= r_stat_stall + 1'b1;
        end
    end

    assign stat_wr_beats = r_stat_wr;
    assign stat_rd_beats = r_stat_rd;
    assign stat_stall    = r_stat_stall;
`else
    assign stat_wr_beats = '0;
    assign stat_rd_beats = '0;
    assign stat_stall    = '0;
`endif

endmodule

// File: tb/tb_ddr2_local_master.sv
// Self-checking bench for ddr2_local_master: vector table plus scoreboarded burst sequences.
module tb_ddr2_local_master;

    logic clk = 1'b0;
    logic reset;
    logic [31:0] stat_wr_beats, stat_rd_beats, stat_stall;

    always #5 clk = ~clk;

    ddr2_local_master_if #(.ADDR_W(25), .DATA_W(64), .BE_W(8), .SIZE_W(3)) lif ();

    ddr2_local_master #(
        .ADDR_W(25), .DATA_W(64), .BE_W(8), .SIZE_W(3), .MAX_BURST(4), .RD_DEPTH(16)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (lif),
        .stat_wr_beats (stat_wr_beats),
        .stat_rd_beats (stat_rd_beats),
        .stat_stall    (stat_stall)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  be;
    } wbeat_t;

    typedef struct {
        logic       wr;
        logic [2:0] len;
        logic       init;
        logic       exp_rdy;
        logic       exp_err;
    } vec_t;

    wbeat_t      wq[$];
    logic [63:0] rq[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] be_of(input int b);
        logic [7:0] t;
        t = 8'hA5;
        return t ^ 8'(b * 37);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every DUT transfer pops the oldest expected beat.
    always @(negedge clk) begin
        if (!reset) begin
            if (lif.local_write_req && lif.local_ready) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected_beat", 64'(lif.local_wdata), 64'hDEAD);
                end else begin
                    wbeat_t e;
                    e = wq.pop_front();
                    chk("wr_data", lif.local_wdata, e.data);
                    chk("wr_be", 64'(lif.local_be), 64'(e.be));
                end
            end
            if (lif.rd_valid && lif.rd_ready) begin
                if (rq.size() == 0) begin
                    chk("rd_unexpected_beat", lif.rd_data, 64'hDEAD);
                end else begin
                    chk("rd_data", lif.rd_data, rq.pop_front());
                end
            end
        end
    end

    task automatic do_reset;
        reset = 1'b1;
        lif.cmd_valid = 0; lif.cmd_write = 0; lif.cmd_addr = '0; lif.cmd_len = '0;
        lif.wr_valid = 0; lif.wr_data = '0; lif.wr_be = '0; lif.rd_ready = 0;
        lif.local_ready = 0; lif.local_rdata = '0; lif.local_rdata_valid = 0;
        lif.local_init_done = 0;
        tick;
        tick;
        wq.delete();
        rq.delete();
        reset = 1'b0;
    endtask

    task automatic run_write(input logic [24:0] addr, input logic [63:0] base,
                             input logic [15:0] vpat, input logic [15:0] rpat, input int ncyc);
        int beat;
        beat = 0;
        for (int b = 0; b < 4; b++) wq.push_back('{base + 64'(b), be_of(b)});
        lif.cmd_valid = 1; lif.cmd_write = 1; lif.cmd_addr = addr; lif.cmd_len = 3'd4;
        lif.wr_valid = 0; lif.local_ready = 1;
        @(negedge clk);
        chk("wr_cmd_ready", 64'(lif.cmd_ready), 64'(1));
        tick;
        lif.cmd_valid = 0;
        for (int c = 0; c < ncyc; c++) begin
            lif.wr_valid = vpat[c]; lif.local_ready = rpat[c];
            lif.wr_data = base + 64'(beat); lif.wr_be = be_of(beat);
            @(negedge clk);
            chk("wr_req", 64'(lif.local_write_req), 64'(vpat[c]));
            chk("wr_burstbegin", 64'(lif.local_burstbegin), 64'((beat == 0) && vpat[c]));
            chk("wr_ready", 64'(lif.wr_ready), 64'(rpat[c]));
            chk("wr_addr", 64'(lif.local_address), 64'(addr));
            chk("wr_size", 64'(lif.local_size), 64'(4));
            @(posedge clk);
            if (vpat[c] && rpat[c]) beat++;
            #1;
        end
        lif.wr_valid = 0; lif.local_ready = 1;
        @(negedge clk);
        chk("wr_beat_count", 64'(beat), 64'(4));
        chk("wr_back_idle", 64'(lif.cmd_ready), 64'(1));
        chk("wr_req_after", 64'(lif.local_write_req), 64'(0));
        chk("wr_sb_drained", 64'(wq.size()), 64'(0));
        tick;
    endtask

    task automatic issue_read(input logic [24:0] addr, input logic [2:0] len, input bit stall);
        lif.cmd_valid = 1; lif.cmd_write = 0; lif.cmd_addr = addr; lif.cmd_len = len;
        lif.local_ready = 1;
        @(negedge clk);
        chk("rd_cmd_ready", 64'(lif.cmd_ready), 64'(1));
        tick;
        lif.cmd_valid = 0;
        if (stall) begin
            lif.local_ready = 0;
            @(negedge clk);
            chk("rd_req_stalled", 64'(lif.local_read_req), 64'(1));
            tick;
            lif.local_ready = 1;
        end
        @(negedge clk);
        chk("rd_req", 64'(lif.local_read_req), 64'(1));
        chk("rd_burstbegin", 64'(lif.local_burstbegin), 64'(1));
        chk("rd_addr", 64'(lif.local_address), 64'(addr));
        chk("rd_size", 64'(lif.local_size), 64'(len));
        tick;
        @(negedge clk);
        chk("rd_req_dropped", 64'(lif.local_read_req), 64'(0));
        tick;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   sent;
        int   exp_occ;
        vt[0] = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b1};
        vt[1] = '{1'b0, 3'd5, 1'b1, 1'b1, 1'b1};
        vt[2] = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b1};
        vt[3] = '{1'b1, 3'd7, 1'b1, 1'b1, 1'b1};
        vt[4] = '{1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b1, 3'd4, 1'b0, 1'b0, 1'b0};

        // Reset state
        do_reset;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(lif.cmd_ready), 64'(0));
        chk("rst_wr_ready", 64'(lif.wr_ready), 64'(0));
        chk("rst_rd_valid", 64'(lif.rd_valid), 64'(0));
        chk("rst_rd_data", lif.rd_data, 64'(0));
        chk("rst_cmd_err", 64'(lif.cmd_err), 64'(0));
        chk("rst_req", 64'({lif.local_read_req, lif.local_write_req, lif.local_burstbegin}), 64'(0));
        chk("rst_addr", 64'(lif.local_address), 64'(0));
        chk("rst_size", 64'(lif.local_size), 64'(0));
        chk("rst_wdata_be", 64'(lif.local_wdata) | 64'(lif.local_be), 64'(0));
        tick;

        // Illegal lengths and init_done gating
        lif.local_ready = 1;
        for (int i = 0; i < 6; i++) begin
            lif.cmd_write = vt[i].wr; lif.cmd_len = vt[i].len; lif.local_init_done = vt[i].init;
            lif.cmd_addr = 25'h1234; lif.cmd_valid = 1;
            @(negedge clk);
            chk($sformatf("vec%0d_cmd_ready", i), 64'(lif.cmd_ready), 64'(vt[i].exp_rdy));
            tick;
            lif.cmd_valid = 0;
            @(negedge clk);
            chk($sformatf("vec%0d_cmd_err", i), 64'(lif.cmd_err), 64'(vt[i].exp_err));
            chk($sformatf("vec%0d_no_req", i), 64'(lif.local_read_req | lif.local_write_req), 64'(0));
            chk($sformatf("vec%0d_addr_kept", i), 64'(lif.local_address), 64'(0));
            tick;
            @(negedge clk);
            chk($sformatf("vec%0d_err_pulse", i), 64'(lif.cmd_err), 64'(0));
            tick;
        end

        // Write bursts: continuous, then with ready stalls and a valid gap
        lif.local_init_done = 1;
        run_write(25'h000100, 64'h1111_0000, 16'h000F, 16'h000F, 4);
        run_write(25'h000200, 64'h2222_0000, 16'h006F, 16'h0079, 7);

        // Read credit limit
        do_reset;
        lif.local_init_done = 1;
        for (int i = 0; i < 4; i++) issue_read(25'(32'h300 + 4 * i), 3'd4, i == 1);
        lif.cmd_valid = 1; lif.cmd_write = 0; lif.cmd_len = 3'd4;
        @(negedge clk);
        chk("credit_block", 64'(lif.cmd_ready), 64'(0));
        tick;
        lif.cmd_valid = 0;
        for (int b = 0; b < 4; b++) begin
            lif.local_rdata_valid = 1; lif.local_rdata = 64'hC0 + 64'(b);
            rq.push_back(64'hC0 + 64'(b));
            tick;
        end
        lif.local_rdata_valid = 0;
        @(negedge clk);
        chk("credit_fifo_valid", 64'(lif.rd_valid), 64'(1));
        tick;
        lif.rd_ready = 1;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            chk("credit_still_blocked", 64'(lif.cmd_ready), 64'(0));
            tick;
        end
        lif.rd_ready = 0;
        @(negedge clk);
        chk("credit_returned", 64'(lif.cmd_ready), 64'(1));
        chk("credit_sb_drained", 64'(rq.size()), 64'(0));
        tick;

        // Read data ordering with rd_ready toggling
        do_reset;
        lif.local_init_done = 1;
        issue_read(25'h000500, 3'd4, 1'b0);
        issue_read(25'h000504, 3'd4, 1'b0);
        sent = 0;
        for (int c = 0; c < 80 && (sent < 8 || rq.size() != 0); c++) begin
            exp_occ = rq.size();
            lif.local_rdata_valid = (sent < 8) && (c % 3 != 2);
            if (lif.local_rdata_valid) begin
                lif.local_rdata = 64'hA0 + 64'(sent);
                rq.push_back(64'hA0 + 64'(sent));
                sent++;
            end
            lif.rd_ready = (sent >= 8) || (c % 2 == 1);
            @(negedge clk);
            chk("ord_fifo_count", 64'(u_dut.w_fifo_count), 64'(exp_occ));
            chk("ord_rd_valid", 64'(lif.rd_valid), 64'(exp_occ != 0));
            tick;
        end
        lif.local_rdata_valid = 0; lif.rd_ready = 0;
        @(negedge clk);
        chk("ord_all_sent", 64'(sent), 64'(8));
        chk("ord_sb_drained", 64'(rq.size()), 64'(0));
        chk("ord_credits_back", 64'(u_dut.r_credits), 64'(16));
        tick;

        // Reset in the middle of a write burst
        do_reset;
        lif.local_init_done = 1; lif.local_ready = 1;
        for (int b = 0; b < 2; b++) wq.push_back('{64'h4444_0000 + 64'(b), be_of(b)});
        lif.cmd_valid = 1; lif.cmd_write = 1; lif.cmd_addr = 25'h000400; lif.cmd_len = 3'd4;
        @(negedge clk);
        chk("rstw_cmd_ready", 64'(lif.cmd_ready), 64'(1));
        tick;
        lif.cmd_valid = 0;
        for (int b = 0; b < 2; b++) begin
            lif.wr_valid = 1; lif.wr_data = 64'h4444_0000 + 64'(b); lif.wr_be = be_of(b);
            @(negedge clk);
            chk("rstw_req", 64'(lif.local_write_req), 64'(1));
            tick;
        end
        lif.wr_data = 64'h4444_0002; lif.wr_be = be_of(2);
        reset = 1;
        tick;
        reset = 0;
        lif.cmd_write = 0; lif.cmd_len = 3'd4;
        @(negedge clk);
        chk("rstw_req_dropped", 64'(lif.local_write_req), 64'(0));
        chk("rstw_bb", 64'(lif.local_burstbegin), 64'(0));
        chk("rstw_addr", 64'(lif.local_address), 64'(0));
        chk("rstw_size", 64'(lif.local_size), 64'(0));
        chk("rstw_wdata", lif.local_wdata, 64'(0));
        chk("rstw_be", 64'(lif.local_be), 64'(0));
        chk("rstw_wr_ready", 64'(lif.wr_ready), 64'(0));
        chk("rstw_idle", 64'(lif.cmd_ready), 64'(1));
        chk("rstw_credits", 64'(u_dut.r_credits), 64'(16));
        chk("rstw_sb_drained", 64'(wq.size()), 64'(0));
        tick;
        lif.wr_valid = 0;
        lif.local_init_done = 0;
        @(negedge clk);
        chk("init_blocks_ready", 64'(lif.cmd_ready), 64'(0));
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
